led_blink_ctrl: RTL and testbench
=================================

// Module: led_blink_ctrl
// PURPOSE
//   Parametrised multi-channel LED blinker; successor of the single-LED CLOCK_50 toggler.
//   Per-channel mode (OFF/ON/BLINK/BURST), programmable half-period and burst pulse count.
//   Sits between board LEDs and control logic. Reset state reproduces the legacy blink on every channel.
// PARAMETERS
//   N_CH         4           number of LED channels (>=2)
//   CNT_W        26          half-period counter width
//   PUL_W        8           burst pulse-count width
//   DEFAULT_HALF 25_000_000  half-period loaded at reset (0.5 s at 50 MHz)
//   CH_W         $clog2(N_CH) channel-select width (derived, localparam)
// PORTS
//   CLOCK_50    in   1      system clock, all logic on rising edge
//   reset       in   1      synchronous, active-high
//   run         in   1      1 = counters advance; 0 = freeze all counters and LED state
//   cfg_we      in   1      1-cycle config write strobe
//   cfg_ch      in   CH_W   channel addressed by cfg_we
//   cfg_mode    in   2      00 OFF, 01 ON, 10 BLINK, 11 BURST
//   cfg_half    in   CNT_W  half-period value H (toggle every H+1 cycles)
//   cfg_pulses  in   PUL_W  BURST pulse count P
//   LED         out  N_CH   per-channel LED drive (registered)
//   LED_N       out  N_CH   bitwise complement of LED
//   busy        out  N_CH   1 while channel in BLINK, or BURST with pulses remaining
//   done        out  N_CH   1-cycle pulse when a BURST completes
// BEHAVIOUR
//   Reset: every channel mode=BLINK, half=DEFAULT_HALF, cnt=0, rem=0, LED=0, LED_N=all 1, busy=all 1, done=0.
//   Reset has priority over cfg_we and run in the same cycle.
//   Config write (cfg_we=1, cfg_ch<N_CH): next edge loads mode/half/rem=cfg_pulses, cnt=0,
//     LED=1 if mode ON else 0, done=0. cfg_ch>=N_CH: write ignored, no state change.
//   Write takes effect regardless of run; restarts channel mid-blink/mid-burst (abort, no done).
//   Per channel, when run=1:
//     OFF:   LED=0, cnt held 0, busy=0.
//     ON:    LED=1, cnt held 0, busy=0.
//     BLINK: if cnt==H {LED<=~LED; cnt<=0} else cnt<=cnt+1. Toggle every H+1 cycles;
//            H=0 -> toggle every cycle. busy=1.
//     BURST: as BLINK while rem!=0. On a 1->0 toggle rem<=rem-1; if that makes rem 0,
//            channel goes idle (LED held 0, cnt 0) and done=1 for exactly that cycle.
//            Written with P=0: idle immediately, done pulses 1 cycle after write, LED stays 0.
//            busy = (rem!=0).
//   run=0: cnt, LED, rem frozen; no toggles, no done pulses; config writes still accepted.
//   Counter compare is equality on CNT_W bits; cnt never exceeds H, no wrap past 2^CNT_W.
//   Channels independent; writing one channel never disturbs the others.
//   LED_N = ~LED combinationally; no other combinational paths input->output.
// TESTING
//   1 reset, run=1, DEFAULT_HALF overridden to 5000 -> all LED rise at cycle 5001, fall at 10002.
//   2 write ch1 BLINK H=0 -> LED[1] toggles every cycle from 2nd edge after write; others unaffected.
//   3 write ch2 BURST H=3 P=2 -> LED[2] 4 hi/4 lo twice, done[2]=1 one cycle at final fall, busy[2]->0.
//   4 write ch0 ON then OFF; write with cfg_ch=N_CH -> LED[0]=1 then 0; invalid write no effect.
//   5 run=0 for 100 cycles mid-blink -> LED/cnt frozen, resume exact phase; write BURST P=0 -> done 1 cycle.
//   6 reset asserted with cfg_we same cycle mid-burst -> reset state, write discarded, no done.

Source files
------------

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blinker. Each channel runs its own OFF/ON/BLINK/BURST
// sequencer. After reset every channel repeats the legacy free-running
// CLOCK_50 blink.

// One LED channel: config latch, half-period counter and burst pulse counter.
module led_blink_ch #(
    parameter int CNT_W        = 26,
    parameter int PUL_W        = 8,
    parameter int DEFAULT_HALF = 25_000_000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [PUL_W-1:0] cfg_pulses,
    output logic             led,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    mode_t            mode, mode_nx;
    logic [CNT_W-1:0] half, half_nx;
    logic [CNT_W-1:0] cnt,  cnt_nx;
    logic [PUL_W-1:0] rem,  rem_nx;
    logic             led_nx;
    logic             done_nx;
    // A burst written with zero pulses still owes one done pulse on the
    // first running cycle; this flag remembers that debt.
    logic             zero_pend, zero_pend_nx;

    // State register; reset wins over any write or run in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mode      <= MODE_BLINK;
            half      <= HALF_RST;
            cnt       <= '0;
            rem       <= '0;
            led       <= 1'b0;
            done      <= 1'b0;
            zero_pend <= 1'b0;
        end else begin
            mode      <= mode_nx;
            half      <= half_nx;
            cnt       <= cnt_nx;
            rem       <= rem_nx;
            led       <= led_nx;
            done      <= done_nx;
            zero_pend <= zero_pend_nx;
        end
    end

    // Next state: a write restarts the channel; otherwise advance only when run=1.
    always_comb begin
        mode_nx      = mode;
        half_nx      = half;
        cnt_nx       = cnt;
        rem_nx       = rem;
        led_nx       = led;
        done_nx      = 1'b0;
        zero_pend_nx = zero_pend;

        if (cfg_we) begin
            mode_nx      = mode_t'(cfg_mode);
            half_nx      = cfg_half;
            rem_nx       = cfg_pulses;
            cnt_nx       = '0;
            led_nx       = (mode_t'(cfg_mode) == MODE_ON);
            zero_pend_nx = (mode_t'(cfg_mode) == MODE_BURST) && (cfg_pulses == '0);
        end else if (run) begin
            case (mode)
                MODE_OFF: begin
                    led_nx = 1'b0;
                    cnt_nx = '0;
                end
                MODE_ON: begin
                    led_nx = 1'b1;
                    cnt_nx = '0;
                end
                MODE_BLINK: begin
                    if (cnt == half) begin
                        led_nx = ~led;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin // MODE_BURST
                    if (zero_pend) begin
                        done_nx      = 1'b1;
                        zero_pend_nx = 1'b0;
                    end else if (rem != '0) begin
                        if (cnt == half) begin
                            cnt_nx = '0;
                            if (led) begin
                                // Falling edge closes one pulse.
                                led_nx  = 1'b0;
                                rem_nx  = rem - PUL_W'(1);
                                done_nx = (rem == PUL_W'(1));
                            end else begin
                                led_nx = 1'b1;
                            end
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end else begin
                        led_nx = 1'b0;
                        cnt_nx = '0;
                    end
                end
            endcase
        end
    end

    // Busy reflects registered state only.
    always_comb begin
        busy = (mode == MODE_BLINK) || ((mode == MODE_BURST) && (rem != '0));
    end
endmodule

// Top: decodes the config channel select and fans out to the channels.
module led_blink_ctrl #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 26,
    parameter int PUL_W        = 8,
    parameter int DEFAULT_HALF = 25_000_000,
    localparam int CH_W        = $clog2(N_CH)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [PUL_W-1:0] cfg_pulses,
    output logic [N_CH-1:0]  LED,
    output logic [N_CH-1:0]  LED_N,
    output logic [N_CH-1:0]  busy,
    output logic [N_CH-1:0]  done
);
    logic [N_CH-1:0] ch_we;

    // Active-low copy for boards that sink LED current.
    assign LED_N = ~LED;

    // Selects >= N_CH match no channel, so such writes are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        led_blink_ch #(
            .CNT_W       (CNT_W),
            .PUL_W       (PUL_W),
            .DEFAULT_HALF(DEFAULT_HALF)
        ) u_ch (
            .CLOCK_50  (CLOCK_50),
            .reset     (reset),
            .run       (run),
            .cfg_we    (ch_we[i]),
            .cfg_mode  (cfg_mode),
            .cfg_half  (cfg_half),
            .cfg_pulses(cfg_pulses),
            .led       (LED[i]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end
endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: directed scenarios plus random traffic, checked
// each cycle against a phase-arithmetic reference model via a queue.
module tb_led_blink_ctrl;
    localparam int N_CH  = 6;   // not a power of two, so invalid selects exist
    localparam int CNT_W = 26;
    localparam int PUL_W = 8;
    localparam int DEF_H = 5000;
    localparam int CH_W  = $clog2(N_CH);

    localparam int OFF = 0, ON = 1, BLINK = 2, BURST = 3;

    logic             CLOCK_50 = 1'b0;
    logic             reset, run, cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_half;
    logic [PUL_W-1:0] cfg_pulses;
    logic [N_CH-1:0]  LED, LED_N, busy, done;

    led_blink_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PUL_W(PUL_W), .DEFAULT_HALF(DEF_H)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .run(run), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half(cfg_half),
        .cfg_pulses(cfg_pulses), .LED(LED), .LED_N(LED_N), .busy(busy), .done(done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [N_CH-1:0] led;
        logic [N_CH-1:0] busy;
        logic [N_CH-1:0] done;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference: per channel, the config plus the number of running cycles
    // since it was (re)started; outputs follow from plain division.
    int m_mode[N_CH], m_h[N_CH], m_p[N_CH], m_a[N_CH];
    bit m_step[N_CH];

    task automatic model_edge();
        exp_t e;
        e = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (reset) begin
                m_mode[i] = BLINK; m_h[i] = DEF_H; m_p[i] = 0; m_a[i] = 0; m_step[i] = 0;
            end else if (cfg_we && int'(cfg_ch) == i) begin
                m_mode[i] = int'(cfg_mode); m_h[i] = int'(cfg_half);
                m_p[i] = int'(cfg_pulses); m_a[i] = 0; m_step[i] = 0;
            end else if (run) begin
                m_a[i]++; m_step[i] = 1;
            end else begin
                m_step[i] = 0;
            end
            case (m_mode[i])
                OFF: ;
                ON:  e.led[i] = 1'b1;
                BLINK: begin
                    e.led[i]  = ((m_a[i] / (m_h[i] + 1)) % 2) == 1;
                    e.busy[i] = 1'b1;
                end
                default: begin
                    if (m_p[i] == 0) begin
                        e.done[i] = m_step[i] && m_a[i] == 1;
                    end else if (m_a[i] < 2 * m_p[i] * (m_h[i] + 1)) begin
                        e.led[i]  = ((m_a[i] / (m_h[i] + 1)) % 2) == 1;
                        e.busy[i] = 1'b1;
                    end else begin
                        e.done[i] = m_step[i] && m_a[i] == 2 * m_p[i] * (m_h[i] + 1);
                    end
                end
            endcase
        end
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a new output word; pop and compare.
    always @(negedge CLOCK_50) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("LED",   LED,   e.led);
            chk("LED_N", LED_N, ~e.led);
            chk("busy",  busy,  e.busy);
            chk("done",  done,  e.done);
        end
    end

    task automatic tick(input bit r, input bit rn, input bit we, input int ch,
                        input int md, input int h, input int p);
        reset      = r;
        run        = rn;
        cfg_we     = we;
        cfg_ch     = CH_W'(ch);
        cfg_mode   = 2'(md);
        cfg_half   = CNT_W'(h);
        cfg_pulses = PUL_W'(p);
        @(posedge CLOCK_50);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input bit rn);
        for (int k = 0; k < n; k++) tick(0, rn, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input int md, input int h, input int p);
        tick(0, 1, 1, ch, md, h, p);
    endtask

    initial begin
        reset = 1; run = 0; cfg_we = 0; cfg_ch = '0; cfg_mode = '0;
        cfg_half = '0; cfg_pulses = '0;

        // Reset state, then legacy blink: rise at 5001, fall at 10002.
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 0);
        idle(10010, 1);

        // Every-cycle toggle on ch1.
        wr(1, BLINK, 0, 0);
        idle(10, 1);

        // Two-pulse burst on ch2.
        wr(2, BURST, 3, 2);
        idle(24, 1);

        // ON then OFF on ch0, then writes to nonexistent channels.
        wr(0, ON, 0, 0);
        idle(3, 1);
        wr(0, OFF, 0, 0);
        idle(3, 1);
        wr(N_CH, ON, 1, 1);
        idle(3, 1);
        wr(7, BURST, 0, 0);
        idle(3, 1);

        // Freeze mid-blink, resume, then a zero-pulse burst.
        wr(3, BLINK, 6, 0);
        idle(9, 1);
        idle(100, 0);
        idle(20, 1);
        wr(4, BURST, 2, 0);
        idle(4, 1);
        // Zero-pulse burst written while frozen: done waits for run.
        tick(0, 0, 1, 5, BURST, 1, 0);
        idle(5, 0);
        idle(4, 1);

        // Reset together with a write, mid-burst.
        wr(2, BURST, 3, 2);
        idle(10, 1);
        tick(1, 1, 1, 2, BURST, 1, 1);
        idle(20, 1);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)));
        end

        idle(2, 1);
        @(negedge CLOCK_50);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
